sub_bytes_seq: RTL
==================

# sub_bytes_seq

Byte-serial SubBytes/InvSubBytes engine for the AES round datapath. Accepts a 128-bit state on a start pulse and streams its 16 bytes through one internal two-stage pipelined `sbox` instance, one byte per cycle. It reassembles the substituted bytes into a 128-bit result and pulses `done`. It is the initiator and sequencer for the `sbox` lookup pipeline, and replaces 16 parallel S-box instances in area-constrained builds.

## Interface
- Parameters: none; sizes come from `aes_pkg`.
- `clk` in 1: rising-edge clock.
- `reset` in 1: synchronous, active-high.
- `start` in 1: begin a substitution; sampled only in IDLE or DONE.
- `ende` in 1: 0 = encrypt (SubBytes), 1 = decrypt (InvSubBytes); sampled with `start`.
- `state_in` in 128: input state; sampled with `start`; byte k = `state_in[127-8k -: 8]`.
- `busy` out 1: high in RUN and DRAIN.
- `done` out 1: one-cycle pulse; `state_out` is valid.
- `state_out` out 128: substituted state, same byte placement; holds until the next `start` is accepted.
- `hold` in 1: present only with `SUB_BYTES_SEQ_HOLD_EN`.

## Operation
- FSM states: IDLE, RUN, DRAIN, DONE.
- IDLE/DONE → RUN on `start`:
  - latch `state_in` and `ende`
  - clear issue count `icnt` (4b) and capture count `ccnt` (4b)
- RUN:
  - drive `sbox.din` = byte[`icnt`], `sbox.ende` = latched `ende`, `sbox.enable` = 1
  - `icnt`++ each cycle
  - after `icnt` = 15 is issued → DRAIN
- DRAIN: `sbox.enable` = 1; advances the pipeline for 2 cycles → DONE.
- Capture:
  - a 2-bit valid shift register tracks issued bytes; it advances only when `sbox.enable` is high
  - when the valid bit exits, byte[`ccnt`] of the result register is written from `en_dout` (ende=0) or `de_dout` (ende=1), then `ccnt`++
- DONE:
  - `done` = 1 for one cycle
  - → IDLE, or → RUN if `start` is high (back-to-back)
- `start` in RUN or DRAIN is ignored; there is no queueing.
- `sbox.enable` is 0 in IDLE and DONE, so the sbox pipeline stays frozen.
- The `sbox` reset pin is tied to `reset`.
- Reset values:
  - FSM = IDLE
  - `busy` = 0, `done` = 0
  - `state_out` = 0
  - counters and valid shift register = 0
- Reset mid-operation: the engine aborts, `done` does not fire, and the partial result is discarded (`state_out` = 0).

## Timing
- C0 is the cycle with `start` high in IDLE or DONE.
- Byte k is issued in C(1+k), C1–C16.
- Byte k's result is valid at the sbox output in C(3+k) and captured at the end of that cycle. The last capture is at the end of C18.
- `busy` is high C1–C18. `done` is high in C19.
- Latency: 19 cycles from `start` to `done`. Back-to-back period: 19 cycles.
- `state_out` is stable from C19 until the next result's capture begins. Individual bytes may update from C3 onward during a run.

## Configuration
- Macro: `SUB_BYTES_SEQ_HOLD_EN`.
- Defined:
  - `hold` port exists
  - while `hold` = 1 in RUN or DRAIN: `sbox.enable` = 0, `icnt`/`ccnt`/valid shift register/FSM frozen, no capture
  - latency grows by exactly the number of hold cycles
  - `hold` is ignored in IDLE and DONE
- Undefined: no `hold` port; behaviour is as if `hold` = 0.

## Structure
- `aes_pkg` holds:
  - `typedef logic [127:0] aes_state_t`
  - `localparam NUM_BYTES = 16`
  - `localparam SBOX_LAT = 2`
  - the FSM enum `sbs_state_e`
- Valid-shift depth and DRAIN length are derived from `SBOX_LAT`.
- One sub-module: `sbox` (existing), instantiated once. No other hierarchy.

## Test plan
- Encrypt all-zero state → `state_out` = 0x63 repeated ×16; `done` in C19; `busy` high C1–C18.
- Encrypt `state_in` = 0x000102…0F → 0x637C777BF26B6FC53001672BFED7AB76.
- Decrypt 0x637C777BF26B6FC53001672BFED7AB76 → 0x000102…0F. Then immediately start again in the `done` cycle with encrypt 0x53 ×16 → 0xED ×16, `done` 19 cycles later.
- `start` pulsed again in C5 and C17 → ignored; single `done` in C19; result unchanged.
- Assert `reset` in C10 → next cycle `busy` = 0, `state_out` = 0, no `done`. A following encrypt of all-zero completes correctly (0x63 ×16).
- With `SUB_BYTES_SEQ_HOLD_EN`: `hold` high C4–C6 and C17 → `done` in C23; result is identical to the unheld run.

Source files
------------

// File: rtl/aes_pkg.sv
// Shared AES sizes, state type, sequencer FSM encoding and GF(2^8) S-box helpers.
package aes_pkg;

    localparam int unsigned NUM_BYTES = 16;
    localparam int unsigned SBOX_LAT  = 2;
    localparam int unsigned CNT_W     = $clog2(NUM_BYTES);

    typedef logic [127:0] aes_state_t;

    typedef enum logic [1:0] {
        SBS_IDLE,
        SBS_RUN,
        SBS_DRAIN,
        SBS_DONE
    } sbs_state_e;

    function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] x;
        p = '0;
        x = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ x;
            x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
        end
        return p;
    endfunction

    // a^254 is the multiplicative inverse in GF(2^8), and maps 0 to 0
    function automatic logic [7:0] gf_inv(input logic [7:0] a);
        logic [7:0] r;
        logic [7:0] p;
        r = 8'h01;
        p = a;
        for (int i = 1; i < 8; i++) begin
            p = gf_mul(p, p);
            r = gf_mul(r, p);
        end
        return r;
    endfunction

    function automatic logic [7:0] affine(input logic [7:0] b);
        return b ^ {b[6:0], b[7]} ^ {b[5:0], b[7:6]} ^ {b[4:0], b[7:5]}
                 ^ {b[3:0], b[7:4]} ^ 8'h63;
    endfunction

    function automatic logic [7:0] inv_affine(input logic [7:0] x);
        return {x[6:0], x[7]} ^ {x[4:0], x[7:5]} ^ {x[1:0], x[7:2]} ^ 8'h05;
    endfunction

endpackage

// File: rtl/sub_bytes_seq_if.sv
// Request/result bundle for sub_bytes_seq; hold exists only with SUB_BYTES_SEQ_HOLD_EN.
interface sub_bytes_seq_if;
    import aes_pkg::*;

    logic       start;
    logic       ende;
    aes_state_t state_in;
    logic       busy;
    logic       done;
    aes_state_t state_out;
`ifdef SUB_BYTES_SEQ_HOLD_EN
    logic       hold;

    modport master (output start, ende, state_in, hold, input busy, done, state_out);
    modport slave  (input start, ende, state_in, hold, output busy, done, state_out);
`else
    modport master (output start, ende, state_in, input busy, done, state_out);
    modport slave  (input start, ende, state_in, output busy, done, state_out);
`endif

endinterface

// File: rtl/sbox.sv
// Two-stage pipelined AES S-box; one shared GF inversion serves both directions.
module sbox
    import aes_pkg::*;
(
    input  logic       clk,
    input  logic       reset,
    input  logic       enable,
    input  logic       ende,
    input  logic [7:0] din,
    output logic [7:0] en_dout,
    output logic [7:0] de_dout
);

    logic [7:0] pre_q;
    logic [7:0] inv_c;

    assign inv_c = gf_inv(pre_q);

    // stage 1 undoes the affine map for decrypt, stage 2 inverts and re-applies it for encrypt
    always_ff @(posedge clk) begin
        if (reset) begin
            pre_q   <= '0;
            en_dout <= '0;
            de_dout <= '0;
        end else if (enable) begin
            pre_q   <= ende ? inv_affine(din) : din;
            en_dout <= affine(inv_c);
            de_dout <= inv_c;
        end
    end

endmodule

// File: rtl/sub_bytes_seq.sv
// Byte-serial SubBytes/InvSubBytes sequencer over one pipelined sbox.
// Optional stall input enabled by SUB_BYTES_SEQ_HOLD_EN.
module sub_bytes_seq
    import aes_pkg::*;
(
    input  logic           clk,
    input  logic           reset,
    sub_bytes_seq_if.slave bus
);

    sbs_state_e          state_q;
    sbs_state_e          state_nxt;
    logic [CNT_W-1:0]    icnt;
    logic [CNT_W-1:0]    ccnt;
    logic [SBOX_LAT-1:0] vld;
    aes_state_t          data_q;
    aes_state_t          result_q;
    logic                ende_q;
    logic                busy_q;
    logic                done_q;

    logic                hold_c;
    logic                adv_c;
    logic                issue_c;
    logic                accept_c;
    logic                capture_c;
    logic [CNT_W+2:0]    ibase_c;
    logic [CNT_W+2:0]    cbase_c;
    logic [7:0]          din_c;
    logic [7:0]          en_dout;
    logic [7:0]          de_dout;

`ifdef SUB_BYTES_SEQ_HOLD_EN
    assign hold_c = bus.hold;
`else
    assign hold_c = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (reset) state_q <= SBS_IDLE;
        else       state_q <= state_nxt;
    end

    // icnt wraps to 0 entering DRAIN and then times the pipeline flush
    always_comb begin
        state_nxt = state_q;
        case (state_q)
            SBS_IDLE, SBS_DONE: state_nxt = bus.start ? SBS_RUN : SBS_IDLE;
            SBS_RUN:   if (!hold_c && icnt == CNT_W'(NUM_BYTES - 1)) state_nxt = SBS_DRAIN;
            SBS_DRAIN: if (!hold_c && icnt == CNT_W'(SBOX_LAT - 1))  state_nxt = SBS_DONE;
            default:   state_nxt = SBS_IDLE;
        endcase
    end

    always_comb begin
        adv_c    = 1'b0;
        issue_c  = 1'b0;
        accept_c = 1'b0;
        case (state_q)
            SBS_IDLE, SBS_DONE: accept_c = bus.start;
            SBS_RUN: begin
                adv_c   = !hold_c;
                issue_c = 1'b1;
            end
            SBS_DRAIN: adv_c = !hold_c;
            default: ;
        endcase
    end

    // byte k sits at bit offset 8*(15-k); ~cnt is 15-cnt for a 4-bit counter
    assign ibase_c   = {~icnt, 3'b000};
    assign cbase_c   = {~ccnt, 3'b000};
    assign din_c     = data_q[ibase_c +: 8];
    assign capture_c = adv_c & vld[SBOX_LAT-1];

    sbox u_sbox (
        .clk     (clk),
        .reset   (reset),
        .enable  (adv_c),
        .ende    (ende_q),
        .din     (din_c),
        .en_dout (en_dout),
        .de_dout (de_dout)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            icnt     <= '0;
            ccnt     <= '0;
            vld      <= '0;
            data_q   <= '0;
            result_q <= '0;
            ende_q   <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            busy_q <= (state_nxt == SBS_RUN) || (state_nxt == SBS_DRAIN);
            done_q <= (state_nxt == SBS_DONE);
            if (accept_c) begin
                data_q <= bus.state_in;
                ende_q <= bus.ende;
                icnt   <= '0;
                ccnt   <= '0;
                vld    <= '0;
            end else if (adv_c) begin
                icnt <= icnt + CNT_W'(1);
                vld  <= {vld[SBOX_LAT-2:0], issue_c};
                if (capture_c) begin
                    result_q[cbase_c +: 8] <= ende_q ? de_dout : en_dout;
                    ccnt                   <= ccnt + CNT_W'(1);
                end
            end
        end
    end

    assign bus.busy      = busy_q;
    assign bus.done      = done_q;
    assign bus.state_out = result_q;

endmodule
